fifo_wr_packer: RTL and testbench

FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_wr_packer.sv | 105 ++++++++++
 tb/tb_fifo_wr_packer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : constants shared by the async FIFO and its write-side packer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_IN_WIDTH   = 2;
  localparam int STATS_WIDTH        = 16;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_wr_packer.sv
// ============================================================================
// fifo_wr_packer : packs IN_WIDTH beats into DATA_WIDTH FIFO words through a
//                  one-word holding stage. Optional macro: FIFO_WR_PACKER_STATS_EN
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH   = DEFAULT_IN_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din
`ifdef FIFO_WR_PACKER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] words_written
`endif
);

  localparam int RATIO = DATA_WIDTH / IN_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic [DATA_WIDTH-1:0] acc_q,  acc_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  pend_q, pend_d;

  logic                  accept;
  logic                  complete;
  logic                  write_take;
  logic [DATA_WIDTH-1:0] word;

  assign s_ready    = !(pend_q && fifo_full);
  assign accept     = s_valid && s_ready;
  assign write_take = pend_q && !fifo_full;
  assign complete   = accept && ((cnt_q == CNT_MAX) || s_last);

  // Slices above cnt_q are always zero in acc_q, so a short frame pads with zeros.
  assign word = acc_q | (DATA_WIDTH'(s_data) << (IN_WIDTH * int'(cnt_q)));

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    hold_d = hold_q;
    pend_d = pend_q;
    if (write_take) begin
      pend_d = 1'b0;
    end
    if (accept) begin
      if (complete) begin
        cnt_d  = '0;
        acc_d  = '0;
        hold_d = word;
        pend_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        acc_d  = word;
      end
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      hold_q <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
    end
  end

  assign fifo_wr_en = pend_q;
  assign fifo_din   = hold_q;

`ifdef FIFO_WR_PACKER_STATS_EN
  logic [STATS_WIDTH-1:0] words_q;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
    end else if (write_take) begin
      words_q <= words_q + STATS_WIDTH'(1);
    end
  end

  assign words_written = words_q;
`endif

endmodule : fifo_wr_packer

`default_nettype wire

// File: tb/tb_fifo_wr_packer.sv
// ============================================================================
// tb_fifo_wr_packer : randomized and directed bench for fifo_wr_packer.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_packer;

  localparam int IW    = 2;
  localparam int DW    = 8;
  localparam int RATIO = DW / IW;

  logic          wr_clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_data;
  logic          s_last;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
`ifdef FIFO_WR_PACKER_STATS_EN
  logic [15:0]   words_written;
`endif

  fifo_wr_packer #(.IN_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din)
`ifdef FIFO_WR_PACKER_STATS_EN
    ,
    .words_written (words_written)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: collect accepted beats of the current word, pack by arithmetic.
  logic [IW-1:0] beats[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  time           wr_times[$];
  bit            saw_notready;
  bit            rand_full;

  always @(negedge wr_clk) begin
    if (rst) begin
      beats.delete();
    end else begin
      if (fifo_wr_en && !fifo_full) begin
        got_q.push_back(fifo_din);
        wr_times.push_back($time);
      end
      if (!s_ready) saw_notready = 1'b1;
      if (s_valid && s_ready) begin
        beats.push_back(s_data);
        if (s_last || beats.size() == RATIO) begin
          logic [DW-1:0] w;
          w = '0;
          foreach (beats[i]) w = w + (DW'(beats[i]) << (IW * i));
          exp_q.push_back(w);
          beats.delete();
        end
      end
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic l);
    bit took;
    int n;
    s_valid = 1'b1; s_data = d; s_last = l;
    took = 1'b0; n = 0;
    while (!took && n < 50) begin
      if (rand_full) fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge wr_clk);
      took = s_ready;
      @(posedge wr_clk); #1;
      n++;
    end
    if (!took) begin
      total++; bad++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", n);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge wr_clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fifo_full = 1'b0;
    idle(2);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b need 1", s_ready); end
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b need 0", fifo_wr_en); end
    total++; if (fifo_din !== 8'h00) begin bad++; $display("FAIL reset_din: got %h need 00", fifo_din); end
    fifo_full = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_full: got %b need 1", s_ready); end
    fifo_full = 1'b0;
    rst = 1'b0;
    idle(1);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_basic;
    send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b1);
    total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL basic_wr_en: got %b need 1", fifo_wr_en); end
    total++; if (fifo_din !== 8'h39) begin bad++; $display("FAIL basic_din: got %h need 39", fifo_din); end
    idle(1);
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL basic_one_cycle: got %b need 0", fifo_wr_en); end
    idle(2);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h39) begin
      bad++; $display("FAIL basic_writes: got %0d writes, need one of 39", got_q.size());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_partial;
    send(2'd3, 1'b0); send(2'd1, 1'b1);
    send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0);
    idle(2);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL partial_count: got %0d writes need 2", got_q.size());
    end else begin
      total++; if (got_q[0] !== 8'h07) begin bad++; $display("FAIL partial_short: got %h need 07", got_q[0]); end
      total++; if (got_q[1] !== 8'hAA) begin bad++; $display("FAIL partial_full: got %h need aa", got_q[1]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_stall;
    int stall_bad;
    send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b1);
    fifo_full = 1'b1;
    stall_bad = 0;
    repeat (5) begin
      @(negedge wr_clk);
      total++;
      if (s_ready !== 1'b0 || fifo_din !== 8'h39 || fifo_wr_en !== 1'b1) begin
        bad++; stall_bad++;
        $display("FAIL stall_hold: ready=%b din=%h wr_en=%b need 0/39/1", s_ready, fifo_din, fifo_wr_en);
      end
      @(posedge wr_clk); #1;
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL stall_nowrite: got %0d writes need 0", got_q.size()); end
    fifo_full = 1'b0;
    @(negedge wr_clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b need 1", s_ready); end
    idle(3);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h39) begin
      bad++; $display("FAIL stall_release_write: got %0d writes need one of 39", got_q.size());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    saw_notready = 1'b0;
    wr_times.delete();
    for (int i = 0; i < 8 * RATIO; i++) send(IW'($urandom), 1'b0);
    idle(2);
    total++; if (saw_notready) begin bad++; $display("FAIL b2b_ready: got ready low need always high"); end
    total++;
    if (got_q.size() != 8 || exp_q.size() != 8) begin
      bad++; $display("FAIL b2b_count: got %0d writes need 8 (model %0d)", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_data[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
      end
      for (int i = 1; i < 8; i++) begin
        total++;
        if (wr_times[i] - wr_times[i-1] != 40) begin
          bad++; $display("FAIL b2b_spacing[%0d]: got %0t need 40", i, wr_times[i] - wr_times[i-1]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    send(2'd3, 1'b0); send(2'd3, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(2'd0, 1'b0); send(2'd0, 1'b0); send(2'd0, 1'b0); send(2'd1, 1'b0);
    idle(2);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h40) begin
      bad++; $display("FAIL rst_mid: got %0d writes (first %h) need one of 40", got_q.size(),
                      (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    rand_full = 1'b1;
    for (int i = 0; i < 80; i++) send(IW'($urandom), ($urandom_range(0, 3) == 0));
    rand_full = 1'b0;
    fifo_full = 1'b0;
    idle(3);
    total++;
    if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      bad++; $display("FAIL rand_count: got %0d writes need %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef FIFO_WR_PACKER_STATS_EN
  task automatic test_stats;
    rst = 1'b1; idle(1); rst = 1'b0;
    total++; if (words_written !== 16'd0) begin bad++; $display("FAIL stats_start: got %0d need 0", words_written); end
    s_valid = 1'b1; s_last = 1'b1; s_data = 2'd1; fifo_full = 1'b0;
    repeat (65537) begin @(posedge wr_clk); #1; end
    s_valid = 1'b0; s_last = 1'b0;
    idle(2);
    total++; if (words_written !== 16'd1) begin bad++; $display("FAIL stats_wrap: got %0d need 1", words_written); end
    rst = 1'b1; #1;
    total++; if (words_written !== 16'd0) begin bad++; $display("FAIL stats_reset: got %0d need 0", words_written); end
    idle(1); rst = 1'b0; idle(1);
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    rand_full = 1'b0;
    saw_notready = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_full_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef FIFO_WR_PACKER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_wr_packer

`default_nettype wire
